// File: rtl/read_stage_vrf_issue.sv
// read_stage_vrf_issue: issues granted lane read requests to the VRF read
// port, follows each tag through the fixed-latency VRF pipe and buffers the
// returned data in a credit-protected FIFO for a ready/valid consumer.
// Optional feature macro: READ_STAGE_KILL_EN (instruction-index kill of
// in-flight and queued reads).
`timescale 1ns/1ps
module read_stage_vrf_issue #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  io_in_ready,
  input  logic                  io_in_valid,
  input  logic [4:0]            io_in_bits_vs,
  input  logic [7:0]            io_in_bits_offset,
  input  logic [3:0]            io_in_bits_readSource,
  input  logic [2:0]            io_in_bits_instructionIndex,
  input  logic                  vrfReadRequest_ready,
  output logic                  vrfReadRequest_valid,
  output logic [12:0]           vrfReadRequest_bits_addr,
  input  logic [DATA_WIDTH-1:0] vrfReadResult_data,
  input  logic                  io_out_ready,
  output logic                  io_out_valid,
  output logic [DATA_WIDTH-1:0] io_out_bits_data,
  output logic [3:0]            io_out_bits_readSource,
  output logic [2:0]            io_out_bits_instructionIndex
`ifdef READ_STAGE_KILL_EN
  ,
  input  logic                  io_kill_valid,
  input  logic [2:0]            io_kill_instructionIndex
`endif
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0] src;
    logic [2:0] idx;
  } tag_t;

  logic [READ_LATENCY-1:0] vld_pipe_q;
  tag_t [READ_LATENCY-1:0] tag_pipe_q;
  logic [DATA_WIDTH-1:0]   fifo_data_q [QUEUE_DEPTH];
  tag_t                    fifo_tag_q  [QUEUE_DEPTH];
  logic [PW-1:0]           head_q, tail_q;
  logic [CW-1:0]           count_q;
  logic                    fire, push, pop, nonempty, has_credit;
  int                      inflight, credit;

  assign nonempty = (count_q != '0);
  assign push     = vld_pipe_q[READ_LATENCY-1];

`ifdef READ_STAGE_KILL_EN
  logic [READ_LATENCY-1:0] kill_pipe_q;
  logic [QUEUE_DEPTH-1:0]  fifo_kill_q;
  logic                    head_killed, push_killed;

  // A killed head is hidden from the consumer and dropped on its own.
  assign head_killed  = nonempty & fifo_kill_q[head_q];
  assign io_out_valid = nonempty & ~head_killed;
  assign pop          = (io_out_valid & io_out_ready) | head_killed;
  assign push_killed  = kill_pipe_q[READ_LATENCY-1] |
                        (io_kill_valid &&
                         tag_pipe_q[READ_LATENCY-1].idx == io_kill_instructionIndex);

  // Killed flags along the tag pipe; a freshly accepted request starts clean.
  always_ff @(posedge clock) begin
    if (!reset) begin
      kill_pipe_q <= '0;
    end else begin
      kill_pipe_q[0] <= 1'b0;
      for (int i = 1; i < READ_LATENCY; i++)
        kill_pipe_q[i] <= kill_pipe_q[i-1] |
                          (io_kill_valid && tag_pipe_q[i-1].idx == io_kill_instructionIndex);
    end
  end

  // Killed flags per FIFO slot; a push overwrites the slot's flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fifo_kill_q <= '0;
    end else begin
      for (int j = 0; j < QUEUE_DEPTH; j++) begin
        if (push && tail_q == PW'(j))
          fifo_kill_q[j] <= push_killed;
        else
          fifo_kill_q[j] <= fifo_kill_q[j] |
                            (io_kill_valid && fifo_tag_q[j].idx == io_kill_instructionIndex);
      end
    end
  end
`else
  assign io_out_valid = nonempty;
  assign pop          = io_out_valid & io_out_ready;
`endif

  // Credit: free FIFO slots not yet claimed by in-flight reads; an entry
  // leaving this cycle (consumed or auto-dropped) frees its slot at once.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + int'(vld_pipe_q[i]);
    credit = QUEUE_DEPTH - inflight - int'(count_q) + int'(pop);
  end

  assign has_credit               = (credit != 0);
  assign vrfReadRequest_valid     = io_in_valid & has_credit;
  assign io_in_ready              = has_credit & vrfReadRequest_ready;
  assign fire                     = io_in_valid & io_in_ready;
  assign vrfReadRequest_bits_addr = {io_in_bits_vs, io_in_bits_offset};

  // Valid bits shadow the VRF read latency; cleared by reset so late data drops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= fire;
      for (int i = 1; i < READ_LATENCY; i++)
        vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // Tag payload follows the valid bits; no reset needed.
  always_ff @(posedge clock) begin
    tag_pipe_q[0] <= {io_in_bits_readSource, io_in_bits_instructionIndex};
    for (int i = 1; i < READ_LATENCY; i++)
      tag_pipe_q[i] <= tag_pipe_q[i-1];
  end

  // FIFO storage written at tail when the VRF data lines up with its tag.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[tail_q] <= vrfReadResult_data;
      fifo_tag_q[tail_q]  <= tag_pipe_q[READ_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  assign io_out_bits_data             = fifo_data_q[head_q];
  assign io_out_bits_readSource       = fifo_tag_q[head_q].src;
  assign io_out_bits_instructionIndex = fifo_tag_q[head_q].idx;

  // Credit accounting guarantees a free slot for every push.
  a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
    push |-> count_q != CW'(QUEUE_DEPTH));

endmodule
